// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ clients.
// Latches the winning client's byte, parity select and baud select. Issues a
// one-cycle start strobe, then waits for the transmitter's done pulse or a
// timeout. Acks the owner and inserts one gap cycle before the next grant.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 100000,
    parameter int unsigned TO_W    = 17
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_p_sel,
    input  logic [2*NUM_REQ-1:0] req_baud,
    input  logic                 err_clr,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [7:0]           tx_data,
    output logic                 tx_p_sel,
    output logic [1:0]           tx_baud_sel,
    output logic                 tx_start,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   ack,
    output logic                 timeout_err
);

    localparam int unsigned      PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(NUM_REQ - 1);
    localparam logic [TO_W-1:0]  CNT_MAX = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StGap} state_e;

    state_e             state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   owner_q;
    logic [TO_W-1:0]    cnt_q;

    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   cand;
    logic [7:0]         win_data;
    logic               win_p_sel;
    logic [1:0]         win_baud;
    logic [NUM_REQ-1:0] win_onehot;
    logic [PTR_W-1:0]   next_ptr;

    // Transmitter busy is status only; sequencing relies on tx_done alone.
    logic unused_tx_busy;
    assign unused_tx_busy = tx_busy;

    // Pick the first requester at or after the round-robin pointer.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cand = PTR_W'((int'(ptr_q) + i) % int'(NUM_REQ));
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Select the winner's frame settings.
    always_comb begin
        win_data  = '0;
        win_p_sel = 1'b0;
        win_baud  = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (win_idx == PTR_W'(k)) begin
                win_data  = req_data[8*k +: 8];
                win_p_sel = req_p_sel[k];
                win_baud  = req_baud[2*k +: 2];
            end
        end
    end

    assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
    assign next_ptr   = (owner_q == LAST) ? '0 : owner_q + 1'b1;

    // Arbitration FSM with registered transmitter-side and client-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            tx_data     <= '0;
            tx_p_sel    <= 1'b0;
            tx_baud_sel <= '0;
            tx_start    <= 1'b0;
            grant       <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            ack      <= '0;
            // A timeout below in the same cycle overrides this clear.
            if (err_clr) timeout_err <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (win_valid) begin
                        tx_data     <= win_data;
                        tx_p_sel    <= win_p_sel;
                        tx_baud_sel <= win_baud;
                        tx_start    <= 1'b1;
                        grant       <= win_onehot;
                        owner_q     <= win_idx;
                        cnt_q       <= '0;
                        state_q     <= StBusy;
                    end
                end
                StBusy: begin
                    if (tx_done) begin
                        ack     <= grant;
                        grant   <= '0;
                        ptr_q   <= next_ptr;
                        state_q <= StGap;
                    end else if (cnt_q == CNT_MAX) begin
                        timeout_err <= 1'b1;
                        grant       <= '0;
                        ptr_q       <= next_ptr;
                        state_q     <= StGap;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StGap: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
